// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter: FSM state encoding and default start timeout.
package uart_arb_pkg;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_START = 2'd1;
    localparam logic [1:0] WAIT_DONE  = 2'd2;

    localparam int unsigned START_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of valid scanning from ptr upward, modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!any && valid[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte producers, with start-timeout recovery.
// Optional packet lock (req_last) enabled by defining UART_ARB_PACKET_LOCK_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEFAULT,
    parameter int unsigned PTR_W         = $clog2(NUM_REQ)
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_byte,
`ifdef UART_ARB_PACKET_LOCK_EN
    input  logic [NUM_REQ-1:0]   req_last,
`endif
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 transmit,
    output logic [7:0]           tx_byte,
    input  logic                 is_transmitting,
    output logic [PTR_W-1:0]     grant_id,
    output logic                 busy,
    output logic                 start_err
);

    localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

    logic [1:0]         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] win_onehot;
    logic [PTR_W-1:0]   win_idx;
    logic               win_any;
    logic [7:0]         byte_arr [NUM_REQ];

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (32'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            byte_arr[i] = req_byte[8*i +: 8];
        end
    end

`ifdef UART_ARB_PACKET_LOCK_EN
    logic             lock_q;
    logic [PTR_W-1:0] lock_id;

    // While a packet is open only its owner may win; the pointer stays put until it closes.
    always_comb begin
        eligible = req_valid;
        if (lock_q) begin
            eligible          = '0;
            eligible[lock_id] = req_valid[lock_id];
        end
    end
`else
    always_comb begin
        eligible = req_valid;
    end
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .valid  (eligible),
        .ptr    (rr_ptr),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            transmit  <= 1'b0;
            tx_byte   <= '0;
            req_ready <= '0;
            grant_id  <= '0;
            start_err <= 1'b0;
`ifdef UART_ARB_PACKET_LOCK_EN
            lock_q    <= 1'b0;
            lock_id   <= '0;
`endif
        end else begin
            transmit  <= 1'b0;
            req_ready <= '0;
            start_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!is_transmitting && win_any) begin
                        tx_byte   <= byte_arr[win_idx];
                        req_ready <= win_onehot;
                        transmit  <= 1'b1;
                        grant_id  <= win_idx;
                        cnt       <= '0;
                        state     <= WAIT_START;
`ifdef UART_ARB_PACKET_LOCK_EN
                        if (req_last[win_idx]) begin
                            lock_q <= 1'b0;
                            rr_ptr <= inc_ptr(win_idx);
                        end else begin
                            lock_q  <= 1'b1;
                            lock_id <= win_idx;
                        end
`else
                        rr_ptr    <= inc_ptr(win_idx);
`endif
                    end
                end
                WAIT_START: begin
                    if (is_transmitting) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                        start_err <= 1'b1;
                        state     <= IDLE;
`ifdef UART_ARB_PACKET_LOCK_EN
                        if (lock_q) begin
                            lock_q <= 1'b0;
                            rr_ptr <= inc_ptr(lock_id);
                        end
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!is_transmitting) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random traffic against a
// transaction-level round-robin model and a simple UART busy-flag model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic              CLK = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_byte;
`ifdef UART_ARB_PACKET_LOCK_EN
    logic [NREQ-1:0]   req_last;
`endif
    logic [NREQ-1:0]   req_ready;
    logic              transmit;
    logic [7:0]        tx_byte;
    logic              is_transmitting;
    logic [1:0]        grant_id;
    logic              busy;
    logic              start_err;

    always #5 CLK = ~CLK;

    uart_tx_arbiter #(
        .NUM_REQ       (NREQ),
        .START_TIMEOUT (TMO)
    ) dut (
        .CLK             (CLK),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_byte        (req_byte),
`ifdef UART_ARB_PACKET_LOCK_EN
        .req_last        (req_last),
`endif
        .req_ready       (req_ready),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_transmitting),
        .grant_id        (grant_id),
        .busy            (busy),
        .start_err       (start_err)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Requester side: pending byte per producer, optional renewals, packet flag.
    bit       pend   [NREQ];
    bit [7:0] pbyte  [NREQ];
    int       remain [NREQ];
    bit       plast  [NREQ];
    bit       pkt    [NREQ];
    bit       rand_bytes = 0;
    int       gen_pct    = 0;

    // Reference model state.
    int mptr     = 0;
    bit mlock    = 0;
    int mlock_id = 0;
    int dead_tx  = -1;
    int last_tx  = -1;
    int last_se  = -1;
    int tx_count = 0;
    int grants[$];

    // UART model.
    bit uart_live = 1;
    bit uart_pend = 0;
    int uart_left = 0;
    int frame_lo  = 6;
    int frame_hi  = 6;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        int w;
        int i;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (mptr + k) % NREQ;
            if (w < 0 && pend[i] && (!mlock || i == mlock_id)) w = i;
        end
        return w;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = pend[i];
            req_byte[8*i +: 8] = pbyte[i];
`ifdef UART_ARB_PACKET_LOCK_EN
            req_last[i]        = plast[i];
`endif
        end
    endtask

    task automatic step();
        int w;
        bit exp_se;
        @(posedge CLK);
        #1;
        cyc++;
        if (!rst_n) begin
            check("rst_transmit",  32'(transmit),  0);
            check("rst_req_ready", 32'(req_ready), 0);
            check("rst_tx_byte",   32'(tx_byte),   0);
            check("rst_grant_id",  32'(grant_id),  0);
            check("rst_busy",      32'(busy),      0);
            check("rst_start_err", 32'(start_err), 0);
            mptr    = 0;
            mlock   = 0;
            dead_tx = -1;
        end else begin
            if (transmit === 1'b1) begin
                w = pick();
                check("tx_while_uart_busy", 32'(is_transmitting), 0);
                check("tx_has_candidate",   32'(w >= 0), 1);
                if (w >= 0) begin
                    check("grant_id",     32'(grant_id),  w);
                    check("tx_byte",      32'(tx_byte),   32'(pbyte[w]));
                    check("req_ready",    32'(req_ready), 1 << w);
                    check("busy_launch",  32'(busy),      1);
                    grants.push_back(w);
                    tx_count++;
                    last_tx = cyc;
                    if (pkt[w] && !plast[w]) begin
`ifdef UART_ARB_PACKET_LOCK_EN
                        mlock    = 1;
                        mlock_id = w;
`else
                        mptr = (w + 1) % NREQ;
`endif
                    end else begin
                        mlock = 0;
                        mptr  = (w + 1) % NREQ;
                    end
                    if (!uart_live) dead_tx = cyc;
                    if (remain[w] > 0) begin
                        remain[w]--;
                        if (pkt[w]) plast[w] = (remain[w] == 0);
                        if (rand_bytes) pbyte[w] = 8'($urandom);
                    end else begin
                        pend[w] = 0;
                    end
                end
            end else begin
                check("req_ready_quiet", 32'(req_ready), 0);
            end
            exp_se = (dead_tx >= 0) && (cyc == dead_tx + TMO);
            check("start_err", 32'(start_err), 32'(exp_se));
            if (start_err === 1'b1) last_se = cyc;
            if (exp_se) begin
                dead_tx = -1;
                if (mlock) begin
                    mlock = 0;
                    mptr  = (mlock_id + 1) % NREQ;
                end
            end
        end
        if (uart_left > 0) begin
            uart_left--;
            if (uart_left == 0) is_transmitting = 1'b0;
        end else if (uart_pend) begin
            uart_pend       = 0;
            is_transmitting = 1'b1;
            uart_left       = $urandom_range(frame_hi, frame_lo);
        end
        if (transmit === 1'b1 && uart_live) uart_pend = 1;
        if (gen_pct > 0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(99, 0) < gen_pct) begin
                    pend[i]   = 1;
                    pbyte[i]  = 8'($urandom);
                    remain[i] = 0;
                    plast[i]  = 1;
                    pkt[i]    = 0;
                end
            end
        end
        drive();
    endtask

    task automatic request(input int i, input bit [7:0] b, input int more, input bit is_pkt);
        pend[i]   = 1;
        pbyte[i]  = b;
        remain[i] = more;
        pkt[i]    = is_pkt;
        plast[i]  = is_pkt ? (more == 0) : 1'b1;
        drive();
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 0;
        for (int k = 0; k < 800 && !done; k++) begin
            step();
            done = 1;
            for (int i = 0; i < NREQ; i++) if (pend[i]) done = 0;
            if (busy !== 1'b0 || is_transmitting || uart_pend) done = 0;
        end
        check(tag, 32'(done), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int exp_order [5];
        int lock_order [4];
        int t0;
        int n0;
        bit seen;

        rst_n           = 1'b0;
        is_transmitting = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; pbyte[i] = 8'h00; remain[i] = 0; plast[i] = 1; pkt[i] = 0;
        end
        drive();
        step(); step(); step();
        rst_n = 1'b1;
        step();

        // Single requester: launch one cycle after sampling, busy until the UART goes idle.
        request(0, 8'h41, 0, 0);
        step();
        check("t1_transmit",  32'(transmit),  1);
        check("t1_tx_byte",   32'(tx_byte),   32'h41);
        check("t1_req_ready", 32'(req_ready), 32'h1);
        step();
        check("t1_transmit_pulse",  32'(transmit),  0);
        check("t1_req_ready_pulse", 32'(req_ready), 0);
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            check("t1_busy_hold", 32'(busy), 1);
            if (is_transmitting) seen = 1;
            else if (seen) break;
        end
        check("t1_uart_ran", 32'(seen), 1);
        step();
        check("t1_busy_clear", 32'(busy), 0);

        // All four continuously valid from pointer 0.
        do_reset();
        grants.delete();
        for (int i = 0; i < NREQ; i++) request(i, 8'(8'h10 + i), 4, 0);
        for (int k = 0; k < 400 && grants.size() < 5; k++) step();
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++)
            check("t2_order", (k < grants.size()) ? grants[k] : -1, exp_order[k]);
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        drive();
        wait_idle("t2_drain");

        // Dead UART: start_err after the timeout, then the next waiting requester is granted.
        uart_live = 0;
        request(2, 8'h77, 0, 0);
        n0 = tx_count;
        for (int k = 0; k < 10 && tx_count == n0; k++) step();
        check("t3_launched", 32'(tx_count > n0), 1);
        t0 = last_tx;
        request(3, 8'h88, 0, 0);
        last_se = -1;
        for (int k = 0; k < 40 && last_se < 0; k++) step();
        check("t3_err_delay", last_se - t0, TMO);
        check("t3_idle_on_err", 32'(busy), 0);
        for (int k = 0; k < 5 && tx_count < n0 + 2; k++) step();
        check("t3_next_grant_cyc", last_tx - t0, TMO + 1);
        check("t3_next_grant_id", grants[grants.size()-1], 3);
        last_se = -1;
        for (int k = 0; k < 40 && last_se < 0; k++) step();
        check("t3_second_err", last_se - last_tx, TMO);
        uart_live = 1;
        wait_idle("t3_drain");

        // Reset during WAIT_DONE: next grant waits for the in-flight frame to finish.
        frame_lo = 20; frame_hi = 20;
        request(1, 8'h5A, 0, 0);
        for (int k = 0; k < 20 && !is_transmitting; k++) step();
        step();
        check("t4_in_frame", 32'(is_transmitting && busy), 1);
        request(2, 8'hC3, 0, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n0 = tx_count;
        for (int k = 0; k < 60 && tx_count == n0; k++) step();
        check("t4_regrant", 32'(tx_count), n0 + 1);
        check("t4_regrant_id", grants[grants.size()-1], 2);
        wait_idle("t4_drain");

        // Wrap-around: grant 2 moves pointer to 3, then 3, then wrap to 0.
        frame_lo = 4; frame_hi = 4;
        do_reset();
        grants.delete();
        request(2, 8'h22, 0, 0);
        wait_idle("t5_a");
        request(3, 8'h33, 0, 0);
        wait_idle("t5_b");
        request(0, 8'h00, 0, 0);
        wait_idle("t5_c");
        check("t5_n", grants.size(), 3);
        if (grants.size() == 3) begin
            check("t5_g0", grants[0], 2);
            check("t5_g1", grants[1], 3);
            check("t5_g2", grants[2], 0);
        end
        check("t5_grant_id", 32'(grant_id), 0);

        // Random traffic.
        frame_lo = 2; frame_hi = 9;
        rand_bytes = 1;
        gen_pct = 30;
        n0 = tx_count;
        for (int k = 0; k < 600; k++) step();
        gen_pct = 0;
        wait_idle("t6_drain");
        check("t6_traffic", 32'(tx_count - n0 > 20), 1);
        rand_bytes = 0;

`ifdef UART_ARB_PACKET_LOCK_EN
        // Packet lock: requester 1's three-byte packet is not interleaved with requester 2.
        do_reset();
        grants.delete();
        request(1, 8'hA0, 2, 1);
        request(2, 8'hB0, 0, 0);
        wait_idle("t7_drain");
        lock_order = '{1, 1, 1, 2};
        check("t7_n", grants.size(), 4);
        for (int k = 0; k < 4; k++)
            check("t7_order", (k < grants.size()) ? grants[k] : -1, lock_order[k]);
`else
        lock_order = '{0, 0, 0, 0};
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
